// File: rtl/mem_dump_unit_if.sv
// Bundles the memory read port and the beat stream used by mem_dump_unit.
// master = the dump engine, slave = the memory/consumer side.
interface mem_dump_unit_if #(
  parameter int word_size = 8,
  parameter int addr_size = 8
);
  logic                 mem_sel;
  logic [addr_size-1:0] mem_addr;
  logic [word_size-1:0] mem_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [addr_size-1:0] out_addr;
  logic [word_size-1:0] out_data;

  modport master (
    output mem_sel, mem_addr, out_valid, out_addr, out_data,
    input  mem_data, out_ready
  );

  modport slave (
    input  mem_sel, mem_addr, out_valid, out_addr, out_data,
    output mem_data, out_ready
  );
endinterface

// File: rtl/mem_dump_unit.sv
// Post-run memory readback: scans an address window once the CPU halts and
// streams (address, data) beats while accumulating a modulo checksum.
module mem_dump_unit #(
  parameter int word_size = 8,
  parameter int addr_size = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dump_start,
  input  logic [addr_size-1:0] start_addr,
  input  logic [addr_size-1:0] end_addr,
  input  logic                 cpu_halted,
  mem_dump_unit_if.master      bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [word_size-1:0] checksum
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_HALT = 3'd1;
  localparam logic [2:0] READ      = 3'd2;
  localparam logic [2:0] SEND      = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;

  logic [2:0]           state;
  logic [addr_size-1:0] cur_addr;
  logic [addr_size-1:0] end_lat;
  logic                 out_valid_q;
  logic [addr_size-1:0] out_addr_q;
  logic [word_size-1:0] out_data_q;
  logic [word_size-1:0] sum_q;
  logic                 err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cur_addr    <= '0;
      end_lat     <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      sum_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dump_start) begin
            cur_addr <= start_addr;
            end_lat  <= end_addr;
            sum_q    <= '0;
            err_q    <= (start_addr > end_addr);
            state    <= (start_addr > end_addr) ? DONE : WAIT_HALT;
          end
        end
        WAIT_HALT: begin
          if (cpu_halted) state <= READ;
        end
        READ: begin
          out_data_q  <= bus.mem_data;
          out_addr_q  <= cur_addr;
          sum_q       <= sum_q + bus.mem_data;
          out_valid_q <= 1'b1;
          state       <= SEND;
        end
        SEND: begin
          // End test before increment so a window ending at the top address never wraps.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (cur_addr == end_lat) begin
              state <= DONE;
            end else begin
              cur_addr <= cur_addr + 1'b1;
              state    <= READ;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_sel   = (state == READ) || (state == SEND);
  assign bus.mem_addr  = cur_addr;
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_data  = out_data_q;
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign err           = err_q;
  assign checksum      = sum_q;

endmodule

// File: tb/tb_mem_dump_unit.sv
// Directed, table-driven bench for mem_dump_unit with a behavioural memory.
module tb_mem_dump_unit;

  logic       clk;
  logic       rst;
  logic       dump_start;
  logic [7:0] start_addr;
  logic [7:0] end_addr;
  logic       cpu_halted;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] checksum;
  logic [7:0] mem [256];

  int checkCount = 0;
  int errCount   = 0;

  mem_dump_unit_if #(.word_size(8), .addr_size(8)) bus ();

  mem_dump_unit #(.word_size(8), .addr_size(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .dump_start (dump_start),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .cpu_halted (cpu_halted),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .checksum   (checksum)
  );

  assign bus.mem_data = mem[bus.mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] s;
    logic [7:0] e;
    int         halt_delay;
    int         stall_beat;
    int         stall_len;
    int         exp_beats;
    logic [7:0] exp_sum;
    logic       exp_err;
    int         exp_done_cyc;
  } vec_t;

  vec_t vecs [7];

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_mem_sel"}, 32'(bus.mem_sel), 0);
    checkOutput({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
    checkOutput({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    checkOutput({tag, "_out_addr"}, 32'(bus.out_addr), 0);
    checkOutput({tag, "_out_data"}, 32'(bus.out_data), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
    checkOutput({tag, "_err"}, 32'(err), 0);
    checkOutput({tag, "_checksum"}, 32'(checksum), 0);
  endtask

  // Runs one dump and checks each beat's position, timing and payload, then the completion status.
  task automatic applyStimulus(input vec_t v, input string tag);
    int         cyc;
    int         beat;
    int         stall_left;
    int         exp_cyc;
    logic       holding;
    logic       sel_seen;
    logic       finished;
    logic [7:0] ea;
    logic [7:0] held_a;
    logic [7:0] held_d;
    cpu_halted = (v.halt_delay == 0);
    bus.out_ready = 1'b1;
    start_addr = v.s;
    end_addr = v.e;
    dump_start = 1'b1;
    stepCycle();
    dump_start = 1'b0;
    cyc = 0;
    beat = 0;
    stall_left = v.stall_len;
    holding = 1'b0;
    sel_seen = 1'b0;
    finished = 1'b0;
    held_a = '0;
    held_d = '0;
    while (!finished && cyc < 60) begin
      if (bus.mem_sel) sel_seen = 1'b1;
      if (v.halt_delay > 0 && cyc <= v.halt_delay) begin
        checkOutput({tag, "_wait_mem_sel"}, 32'(bus.mem_sel), 0);
        checkOutput({tag, "_wait_valid"}, 32'(bus.out_valid), 0);
      end
      if (cyc == v.halt_delay) cpu_halted = 1'b1;
      if (bus.out_valid) begin
        if (!holding) begin
          exp_cyc = 2 + v.halt_delay + 2 * beat +
                    ((v.stall_beat >= 0 && beat > v.stall_beat) ? v.stall_len : 0);
          ea = v.s + 8'(beat);
          checkOutput({tag, "_beat_cycle"}, 32'(cyc), 32'(exp_cyc));
          checkOutput({tag, "_beat_addr"}, 32'(bus.out_addr), 32'(ea));
          checkOutput({tag, "_beat_data"}, 32'(bus.out_data), 32'(mem[ea]));
          checkOutput({tag, "_beat_mem_sel"}, 32'(bus.mem_sel), 1);
          held_a = bus.out_addr;
          held_d = bus.out_data;
          beat++;
        end else begin
          checkOutput({tag, "_hold_addr"}, 32'(bus.out_addr), 32'(held_a));
          checkOutput({tag, "_hold_data"}, 32'(bus.out_data), 32'(held_d));
        end
        if (beat - 1 == v.stall_beat && stall_left > 0) begin
          bus.out_ready = 1'b0;
          stall_left--;
          holding = 1'b1;
        end else begin
          bus.out_ready = 1'b1;
          holding = 1'b0;
        end
      end
      if (done) begin
        finished = 1'b1;
        checkOutput({tag, "_done_cycle"}, 32'(cyc), 32'(v.exp_done_cyc));
        checkOutput({tag, "_beats"}, 32'(beat), 32'(v.exp_beats));
        checkOutput({tag, "_checksum"}, 32'(checksum), 32'(v.exp_sum));
        checkOutput({tag, "_err"}, 32'(err), 32'(v.exp_err));
        checkOutput({tag, "_mem_sel_seen"}, 32'(sel_seen), 32'(v.exp_beats > 0));
      end else begin
        stepCycle();
        cyc++;
      end
    end
    checkOutput({tag, "_timeout"}, 32'(finished), 1);
    bus.out_ready = 1'b1;
    stepCycle();
    checkOutput({tag, "_done_pulse_end"}, 32'(done), 0);
    checkOutput({tag, "_idle_busy"}, 32'(busy), 0);
    checkOutput({tag, "_checksum_held"}, 32'(checksum), 32'(v.exp_sum));
    checkOutput({tag, "_err_held"}, 32'(err), 32'(v.exp_err));
  endtask

  initial begin
    int   n;
    vec_t single;
    rst = 1'b1;
    dump_start = 1'b0;
    start_addr = '0;
    end_addr = '0;
    cpu_halted = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 3 + 7);
    mem[128] = 8'd1;
    mem[129] = 8'd2;
    mem[130] = 8'd3;
    mem[254] = 8'hF0;
    mem[255] = 8'h20;

    vecs[0] = '{8'd128, 8'd130, 0, -1, 0, 3, 8'd6,   1'b0, 7};
    vecs[1] = '{8'd128, 8'd130, 0,  1, 5, 3, 8'd6,   1'b0, 12};
    vecs[2] = '{8'd128, 8'd130, 4, -1, 0, 3, 8'd6,   1'b0, 11};
    vecs[3] = '{8'd10,  8'd5,   0, -1, 0, 0, 8'd0,   1'b1, 0};
    vecs[4] = '{8'd254, 8'd255, 0, -1, 0, 2, 8'h10,  1'b0, 5};
    vecs[5] = '{8'd10,  8'd12,  0, -1, 0, 3, 8'd120, 1'b0, 7};
    vecs[6] = '{8'd200, 8'd200, 0, -1, 0, 1, 8'd95,  1'b0, 3};

    stepCycle();
    stepCycle();
    checkAllZero("reset");
    rst = 1'b0;
    stepCycle();

    for (int i = 0; i < 7; i++) begin
      $display("[TB] vector %0d: window %0d..%0d", i, vecs[i].s, vecs[i].e);
      applyStimulus(vecs[i], $sformatf("v%0d", i));
    end

    // Abort a dump while a beat is parked in SEND.
    cpu_halted = 1'b1;
    start_addr = 8'd128;
    end_addr = 8'd130;
    dump_start = 1'b1;
    stepCycle();
    dump_start = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 10) begin
      stepCycle();
      n++;
    end
    checkOutput("abort_reach_send", 32'(bus.out_valid), 1);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #1;
    checkAllZero("abort");
    #2;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      checkOutput("abort_no_done", 32'(done), 0);
      checkOutput("abort_no_valid", 32'(bus.out_valid), 0);
      checkOutput("abort_idle", 32'(busy), 0);
    end
    single = '{8'd128, 8'd128, 0, -1, 0, 1, 8'd1, 1'b0, 3};
    applyStimulus(single, "after_abort");

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
